// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 encoding constants and types used by the instruction encoder
// and the fetch-stage length decoder.
//   - icode constants (HALT .. POPQ)
//   - REG_NONE register specifier
//   - instruction length type and the four legal lengths
//   - encoder state type
//   - small classification helpers for the byte layout
// ---------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IC_HALT   = 4'h0;
    localparam logic [3:0] IC_NOP    = 4'h1;
    localparam logic [3:0] IC_RRMOVQ = 4'h2;
    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    // "No register" specifier
    localparam logic [3:0] REG_NONE  = 4'hF;

    // Instruction length in bytes
    typedef logic [3:0] ilen_t;

    localparam ilen_t LEN_1  = 4'd1;
    localparam ilen_t LEN_2  = 4'd2;
    localparam ilen_t LEN_9  = 4'd9;
    localparam ilen_t LEN_10 = 4'd10;

    // Longest instruction, sizes the encoder's byte buffer
    localparam int MAX_LEN = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_FAULT = 2'd2
    } enc_state_t;

    // Instructions carrying a register-specifier byte at offset 1
    function automatic logic has_reg_byte(input logic [3:0] icode);
        return (icode inside {IC_RRMOVQ, IC_IRMOVQ, IC_RMMOVQ, IC_MRMOVQ,
                              IC_OPQ, IC_PUSHQ, IC_POPQ});
    endfunction

    // Instructions whose constant word starts at byte 2 (after the register byte)
    function automatic logic valc_at_byte2(input logic [3:0] icode);
        return (icode inside {IC_IRMOVQ, IC_RMMOVQ, IC_MRMOVQ});
    endfunction

    // Instructions whose constant word starts directly at byte 1
    function automatic logic valc_at_byte1(input logic [3:0] icode);
        return (icode inside {IC_JXX, IC_CALL});
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// ---------------------------------------------------------------------------
// y86_instr_len
// Combinational icode -> {valid, length} map. Shared between the encoder and
// the fetch stage so both agree on instruction sizes.
// Ports:
//   icode_i  in  4  instruction code
//   valid_o  out 1  icode is a defined instruction (0..11)
//   len_o    out 4  instruction length in bytes (0 when invalid)
// ---------------------------------------------------------------------------
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic       valid_o,
    output ilen_t      len_o
);

    always_comb begin
        valid_o = 1'b1;
        len_o   = LEN_1;
        case (icode_i)
            IC_HALT, IC_NOP, IC_RET:                 len_o = LEN_1;
            IC_RRMOVQ, IC_OPQ, IC_PUSHQ, IC_POPQ:    len_o = LEN_2;
            IC_JXX, IC_CALL:                         len_o = LEN_9;
            IC_IRMOVQ, IC_RMMOVQ, IC_MRMOVQ:         len_o = LEN_10;
            default: begin
                valid_o = 1'b0;
                len_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// ---------------------------------------------------------------------------
// y86_instr_encoder
// Takes a Y86-64 instruction in field form and streams its byte encoding into
// instruction memory, one byte per clock, starting at the write pointer.
//
// Parameters:
//   IMEM_DEPTH  instruction-memory size in bytes
//   ADDR_W      write-address width (2**ADDR_W >= IMEM_DEPTH)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   instruction handshake
//   in_icode, in_ifun,
//   in_rA, in_rB, in_valC instruction fields
//   base_load, base_addr  reposition the write pointer (IDLE only)
//   clear_err             leave FAULT and clear err_overflow
//   wr_en, wr_addr,
//   wr_data               registered byte-write port to instruction memory
//   wr_ptr                next free byte address
//   busy                  an instruction is being emitted
//   err_invalid           one-cycle pulse after an undefined icode is consumed
//   err_overflow          sticky: instruction would not fit in memory
//
// Build option:
//   Y86_ENC_FIELD_FORCE_EN  when defined, register nibbles that the
//   instruction does not use are written as 0xF (rA of irmovq, rB of
//   pushq/popq); otherwise rA/rB are passed through unchanged.
// ---------------------------------------------------------------------------
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [63:0]       in_valC,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy,
    output logic              err_invalid,
    output logic              err_overflow
);

    // Memory size at ADDR_W+1 bits so an end address of exactly IMEM_DEPTH
    // (and anything past it) is representable without wrapping.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(IMEM_DEPTH);

    enc_state_t                 state_q, state_d;
    logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]                 wr_data_q, wr_data_d;
    logic                       wr_en_q, wr_en_d;
    logic                       err_inv_q, err_inv_d;
    logic                       err_ovf_q, err_ovf_d;
    ilen_t                      idx_q, idx_d;
    ilen_t                      len_q, len_d;
    logic [MAX_LEN-1:0][7:0]    bytes_q, bytes_d;

    logic                       icode_valid;
    ilen_t                      icode_len;
    logic [3:0]                 rA_eff, rB_eff;
    logic [MAX_LEN-1:0][7:0]    enc_bytes;
    logic [ADDR_W:0]            end_addr;
    logic                       fits;
    logic                       accept;

    y86_instr_len u_len (
        .icode_i (in_icode),
        .valid_o (icode_valid),
        .len_o   (icode_len)
    );

    // Register-nibble forcing for unused specifiers
    always_comb begin
        rA_eff = in_rA;
        rB_eff = in_rB;
`ifdef Y86_ENC_FIELD_FORCE_EN
        if (in_icode == IC_IRMOVQ) begin
            rA_eff = REG_NONE;
        end
        if ((in_icode == IC_PUSHQ) || (in_icode == IC_POPQ)) begin
            rB_eff = REG_NONE;
        end
`endif
    end

    // Full byte image of the presented instruction, little-endian constant
    always_comb begin
        enc_bytes    = '0;
        enc_bytes[0] = {in_icode, in_ifun};
        if (has_reg_byte(in_icode)) begin
            enc_bytes[1] = {rA_eff, rB_eff};
        end
        if (valc_at_byte2(in_icode)) begin
            for (int i = 0; i < 8; i++) begin
                enc_bytes[2+i] = in_valC[8*i +: 8];
            end
        end
        if (valc_at_byte1(in_icode)) begin
            for (int i = 0; i < 8; i++) begin
                enc_bytes[1+i] = in_valC[8*i +: 8];
            end
        end
    end

    // End-address check is done one bit wider than the pointer so that an
    // instruction near the top of memory cannot wrap and look like it fits.
    assign end_addr = {1'b0, wr_ptr_q} + {{(ADDR_W + 1 - 4){1'b0}}, icode_len};
    assign fits     = (end_addr <= DEPTH_LIM);

    // base_load has priority over a presented instruction
    assign in_ready = (state_q == ST_IDLE) && !base_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        err_inv_d = 1'b0;
        err_ovf_d = err_ovf_q;
        idx_d     = idx_q;
        len_d     = len_q;
        bytes_d   = bytes_q;

        case (state_q)
            ST_IDLE: begin
                if (base_load) begin
                    wr_ptr_d = base_addr;
                end else if (accept) begin
                    if (!icode_valid) begin
                        // Consumed and reported, nothing written
                        err_inv_d = 1'b1;
                    end else if (!fits) begin
                        err_ovf_d = 1'b1;
                        state_d   = ST_FAULT;
                    end else begin
                        // Byte 0 is driven on the accept edge so the write
                        // strobe is high in the cycle right after accept; the
                        // index therefore restarts at the next byte (1).
                        bytes_d   = enc_bytes;
                        len_d     = icode_len;
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_ptr_q;
                        wr_data_d = enc_bytes[0];
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        idx_d     = LEN_1;
                        state_d   = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                if (idx_q == len_q) begin
                    // Last byte is on the bus this cycle
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q;
                    wr_data_d = bytes_q[idx_q];
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    idx_d     = idx_q + 1'b1;
                end
            end

            ST_FAULT: begin
                if (clear_err) begin
                    err_ovf_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            err_inv_q <= 1'b0;
            err_ovf_q <= 1'b0;
            idx_q     <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            err_inv_q <= err_inv_d;
            err_ovf_q <= err_ovf_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
        end
    end

    // Byte buffer is pure data, only read while in EMIT after being loaded
    always_ff @(posedge clk) begin
        bytes_q <= bytes_d;
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_ptr       = wr_ptr_q;
    assign busy         = (state_q == ST_EMIT);
    assign err_invalid  = err_inv_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
module tb_y86_instr_encoder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_icode = '0;
    logic [3:0]    in_ifun = '0;
    logic [3:0]    in_rA = '0;
    logic [3:0]    in_rB = '0;
    logic [63:0]   in_valC = '0;
    logic          base_load = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          clear_err = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] wr_ptr;
    logic          busy;
    logic          err_invalid;
    logic          err_overflow;

    int            n_checks = 0;
    int            n_pass = 0;
    int            m_ptr = 0;
    logic [7:0]    cap [0:9];

    always #5 clk = ~clk;

    y86_instr_encoder #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC),
        .base_load(base_load), .base_addr(base_addr), .clear_err(clear_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ptr(wr_ptr),
        .busy(busy), .err_invalid(err_invalid), .err_overflow(err_overflow)
    );

    // Reference model: lengths and byte image straight from the ISA tables
    function automatic int ref_len(input logic [3:0] ic);
        case (ic)
            4'd0, 4'd1, 4'd9:          return 1;
            4'd2, 4'd6, 4'd10, 4'd11:  return 2;
            4'd7, 4'd8:                return 9;
            4'd3, 4'd4, 4'd5:          return 10;
            default:                   return 0;
        endcase
    endfunction

    function automatic logic [79:0] ref_encode(input logic [3:0] ic, input logic [3:0] fn,
                                               input logic [3:0] ra, input logic [3:0] rb,
                                               input logic [63:0] vc);
        logic [79:0] r;
        logic [3:0]  a;
        logic [3:0]  b;
        a = ra;
        b = rb;
`ifdef Y86_ENC_FIELD_FORCE_EN
        if (ic == 4'd3) a = 4'hF;
        if (ic == 4'd10 || ic == 4'd11) b = 4'hF;
`endif
        r = '0;
        r[7:0] = {ic, fn};
        if (ic inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11}) r[15:8] = {a, b};
        if (ic inside {4'd3, 4'd4, 4'd5}) r[79:16] = vc;
        if (ic inside {4'd7, 4'd8}) r[71:8] = vc;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; base_load = 1'b0; clear_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_ptr = 0;
    endtask

    // Present one valid instruction and check every emitted byte
    task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] vc);
        int          len;
        int          w;
        logic [79:0] eb;
        logic [AW-1:0] ea;
        len = ref_len(ic);
        eb  = ref_encode(ic, fn, ra, rb, vc);
        in_icode = ic; in_ifun = fn; in_rA = ra; in_rB = rb; in_valC = vc;
        base_load = 1'b0; clear_err = 1'b0;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL accept_ready ic=%0d: got %b expected 1", ic, in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            ea = AW'((m_ptr + i) % DEPTH);
            cap[i] = wr_data;
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== ea || wr_data !== eb[8*i +: 8])
                $display("FAIL byte ic=%0d i=%0d: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                         ic, i, wr_en, wr_addr, wr_data, ea, eb[8*i +: 8]);
            else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL emit_flags ic=%0d i=%0d: got ready=%b busy=%b expected ready=0 busy=1",
                         ic, i, in_ready, busy);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (wr_en !== 1'b0) $display("FAIL after_len ic=%0d: got wr_en=%b expected 0", ic, wr_en);
        else n_pass++;
        w = 0;
        while (in_ready !== 1'b1 && w < 4) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL ready_return ic=%0d: got %b expected 1", ic, in_ready);
        else n_pass++;
        m_ptr = (m_ptr + len) % DEPTH;
        n_checks++;
        if (wr_ptr !== AW'(m_ptr)) $display("FAIL wr_ptr ic=%0d: got %0d expected %0d", ic, wr_ptr, m_ptr);
        else n_pass++;
    endtask

    // base_load with a simultaneous instruction that must not be accepted
    task automatic load_base(input int addr);
        base_load = 1'b1;
        base_addr = AW'(addr);
        in_valid  = 1'b1;
        in_icode  = 4'(ref_len(4'd1));
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL load_prio_ready: got %b expected 0", in_ready);
        else n_pass++;
        @(negedge clk);
        base_load = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (wr_ptr !== AW'(addr) || wr_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL base_load: got ptr=%0d en=%b busy=%b expected ptr=%0d en=0 busy=0",
                     wr_ptr, wr_en, busy, addr);
        else n_pass++;
        m_ptr = addr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_ptr !== '0 || wr_addr !== '0 || wr_data !== '0 ||
            busy !== 1'b0 || err_invalid !== 1'b0 || err_overflow !== 1'b0)
            $display("FAIL reset_state: got en=%b ptr=%0d addr=%0d data=%h busy=%b ei=%b eo=%b expected all 0",
                     wr_en, wr_ptr, wr_addr, wr_data, busy, err_invalid, err_overflow);
        else n_pass++;
        do_reset();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_irmovq_jmp();
        run_instr(4'd3, 4'd0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        n_checks++;
        if (cap[0] !== 8'h30 || cap[1] !== 8'hF3 || cap[2] !== 8'hEF || cap[9] !== 8'h01)
            $display("FAIL irmovq_bytes: got %h %h %h %h expected 30 f3 ef 01", cap[0], cap[1], cap[2], cap[9]);
        else n_pass++;
        run_instr(4'd7, 4'd0, 4'h0, 4'h0, 64'h100);
        n_checks++;
        if (cap[0] !== 8'h70 || cap[1] !== 8'h00 || cap[2] !== 8'h01 || cap[8] !== 8'h00)
            $display("FAIL jmp_bytes: got %h %h %h %h expected 70 00 01 00", cap[0], cap[1], cap[2], cap[8]);
        else n_pass++;
        n_checks++;
        if (wr_ptr !== AW'(19)) $display("FAIL jmp_ptr: got %0d expected 19", wr_ptr);
        else n_pass++;
    endtask

    task automatic test_invalid();
        for (int k = 12; k < 16; k++) begin
            in_icode = 4'(k);
            in_ifun  = 4'($urandom_range(0, 15));
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (err_invalid !== 1'b1 || wr_en !== 1'b0 || wr_ptr !== AW'(m_ptr) || in_ready !== 1'b1 || busy !== 1'b0)
                $display("FAIL invalid_n1 ic=%0d: got ei=%b en=%b ptr=%0d ready=%b busy=%b expected 1 0 %0d 1 0",
                         k, err_invalid, wr_en, wr_ptr, in_ready, busy, m_ptr);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (err_invalid !== 1'b0 || wr_en !== 1'b0)
                $display("FAIL invalid_n2 ic=%0d: got ei=%b en=%b expected 0 0", k, err_invalid, wr_en);
            else n_pass++;
        end
    endtask

    task automatic test_push();
        logic [7:0] exp1;
`ifdef Y86_ENC_FIELD_FORCE_EN
        exp1 = 8'h4F;
`else
        exp1 = 8'h45;
`endif
        run_instr(4'd10, 4'd0, 4'h4, 4'h5, {$urandom, $urandom});
        n_checks++;
        if (cap[0] !== 8'hA0 || cap[1] !== exp1)
            $display("FAIL pushq_bytes: got %h %h expected a0 %h", cap[0], cap[1], exp1);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] ic;
        for (int n = 0; n < 30; n++) begin
            ic = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 7) == 0 || m_ptr + ref_len(ic) > DEPTH)
                load_base(int'($urandom_range(0, DEPTH - 1 - 10)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_instr(ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), {$urandom, $urandom});
        end
    endtask

    task automatic test_overflow();
        // exact fits at the top of memory, pointer wraps to 0
        load_base(1014);
        run_instr(4'd4, 4'd0, 4'h1, 4'h2, {$urandom, $urandom});
        load_base(1023);
        run_instr(4'd0, 4'd0, 4'h0, 4'h0, 64'h0);
        // clear_err in IDLE has no effect
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || err_overflow !== 1'b0 || wr_ptr !== AW'(m_ptr) || wr_en !== 1'b0)
            $display("FAIL clear_idle: got ready=%b eo=%b ptr=%0d en=%b", in_ready, err_overflow, wr_ptr, wr_en);
        else n_pass++;
        // rmmovq from 1020 does not fit
        load_base(1020);
        in_icode = 4'd4; in_valC = 64'hDEAD; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (err_overflow !== 1'b1 || wr_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || wr_ptr !== AW'(1020))
            $display("FAIL overflow: got eo=%b en=%b ready=%b busy=%b ptr=%0d expected 1 0 0 0 1020",
                     err_overflow, wr_en, in_ready, busy, wr_ptr);
        else n_pass++;
        // FAULT ignores base_load and instructions
        base_load = 1'b1; base_addr = AW'(5); in_valid = 1'b1; in_icode = 4'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (err_overflow !== 1'b1 || wr_en !== 1'b0 || in_ready !== 1'b0 || wr_ptr !== AW'(1020))
                $display("FAIL fault_hold c=%0d: got eo=%b en=%b ready=%b ptr=%0d", c, err_overflow, wr_en, in_ready, wr_ptr);
            else n_pass++;
        end
        base_load = 1'b0; in_valid = 1'b0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        n_checks++;
        if (err_overflow !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL clear_err: got eo=%b ready=%b busy=%b expected 0 1 0", err_overflow, in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        in_icode = 4'd3; in_ifun = 4'd0; in_rA = 4'hF; in_rB = 4'h3; in_valC = 64'h0123456789ABCDEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== AW'(2))
            $display("FAIL mid_third_byte: got en=%b addr=%0d expected 1 2", wr_en, wr_addr);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_ptr !== '0 || busy !== 1'b0 || wr_addr !== '0 || wr_data !== '0)
            $display("FAIL async_reset: got en=%b ptr=%0d busy=%b addr=%0d data=%h expected all 0",
                     wr_en, wr_ptr, busy, wr_addr, wr_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL no_resume: got %0d write cycles expected 0", bad);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1 || wr_ptr !== '0)
            $display("FAIL post_reset: got ready=%b ptr=%0d expected 1 0", in_ready, wr_ptr);
        else n_pass++;
        m_ptr = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_irmovq_jmp();
        test_invalid();
        test_push();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/y86_instr_encoder.md
Y86_INSTR_ENCODER -- requirements
Module: y86_instr_encoder

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, giving instruction-memory size in bytes.
REQ-002 SHALL have parameter ADDR_W, default 10, giving the write-address width, where 2^ADDR_W >= IMEM_DEPTH.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an instruction is presented in field form.
- in_ready  out  1  the encoder accepts the presented instruction this cycle.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code.
- in_rA  in  4  register A specifier.
- in_rB  in  4  register B specifier.
- in_valC  in  64  constant word.
- base_load  in  1  load base_addr into the write pointer.
- base_addr  in  ADDR_W  new write-pointer value.
- clear_err  in  1  leave FAULT.
- wr_en  out  1  byte-write strobe to instruction memory.
- wr_addr  out  ADDR_W  byte address being written.
- wr_data  out  8  byte being written.
- wr_ptr  out  ADDR_W  next free byte address.
- busy  out  1  state is EMIT.
- err_invalid  out  1  one-cycle pulse: an invalid icode was consumed.
- err_overflow  out  1  sticky: the instruction would exceed IMEM_DEPTH.

Function
REQ-004 SHALL encode instructions in the Y86-64 byte layout that the fetch stage decodes:
- byte0 = {icode, ifun}.
- For icodes 2, 3, 4, 5, 6, 10 and 11: byte1 = {rA, rB}.
- For icodes 3, 4 and 5: bytes 2..9 = valC, little-endian.
- For icodes 7 and 8: bytes 1..8 = valC, little-endian.
REQ-005 Instruction lengths SHALL be:
- icodes 0, 1 and 9: 1 byte.
- icodes 2, 6, 10 and 11: 2 bytes.
- icodes 7 and 8: 9 bytes.
- icodes 3, 4 and 5: 10 bytes.
- icodes 12..15 are invalid.
REQ-006 The state machine SHALL have three states: IDLE, EMIT and FAULT.
REQ-007 in_ready SHALL equal (state==IDLE && !base_load).
REQ-008 On accept (in_valid && in_ready) with a valid icode and wr_ptr+len <= IMEM_DEPTH, the encoder SHALL latch all fields, clear the byte index, and go to EMIT.
REQ-009 In EMIT, the encoder SHALL emit one byte per cycle:
- Signals: wr_en=1, wr_addr=wr_ptr, wr_data=byte[idx].
- Each cycle: wr_ptr and idx both increment.
- After byte len-1 it SHALL return to IDLE.
REQ-010 Latency: for an accept in cycle N, wr_en SHALL be high in cycles N+1..N+len, and in_ready SHALL be high again no earlier than cycle N+len+1.
REQ-011 On accept of an invalid icode, the encoder SHALL:
- consume the instruction;
- pulse err_invalid in cycle N+1;
- make no write and leave wr_ptr unchanged;
- stay in IDLE.
REQ-012 On accept where wr_ptr+len > IMEM_DEPTH, the encoder SHALL:
- set err_overflow;
- go to FAULT;
- make no write.
REQ-013 The overflow comparison SHALL be computed at ADDR_W+1 bits so that it does not wrap.
REQ-014 FAULT SHALL hold in_ready=0 and wr_en=0; clear_err SHALL clear err_overflow and return the state to IDLE.
REQ-015 base_load in IDLE SHALL set wr_ptr=base_addr in the next cycle; base_load SHALL be ignored in EMIT and FAULT.
REQ-016 in_valid and base_load asserted together in IDLE: the load SHALL take priority and the instruction SHALL NOT be accepted.
REQ-017 clear_err outside FAULT SHALL have no effect.
REQ-018 wr_addr, wr_data and wr_en SHALL be registered outputs.
REQ-019 busy SHALL equal (state==EMIT).

Reset
REQ-020 rst_n low SHALL act immediately, asynchronously and mid-operation, and SHALL set:
- state = IDLE;
- wr_en = 0, wr_addr = 0, wr_data = 0;
- wr_ptr = 0;
- err_invalid = 0, err_overflow = 0;
- byte index = 0.
REQ-021 A partially emitted instruction SHALL be abandoned and SHALL NOT resume after reset.

Configuration
REQ-022 Macro Y86_ENC_FIELD_FORCE_EN controls register-nibble forcing.
- Defined: the encoder SHALL force unused register nibbles to 0xF:
  - rA for icode 3;
  - rB for icodes 10 and 11.
- Undefined: the encoder SHALL pass in_rA and in_rB through unchanged.

Structure
REQ-023 Package y86_pkg SHALL hold:
- the icode constants (HALT=0 .. POPQ=11);
- the REG_NONE=4'hF constant;
- the instruction-length type and values (1, 2, 9, 10).
REQ-024 Sub-module y86_instr_len SHALL be a combinational block that maps icode to {valid, len[3:0]} and is shared with the fetch stage.

Verification
REQ-025 Bench SHALL cover:
- irmovq at base 0: icode=3, ifun=0, rA=F, rB=3, valC=0x0123456789ABCDEF -> bytes 30 F3 EF CD AB 89 67 45 23 01 at addresses 0..9; wr_ptr=10.
- jmp following it: icode=7, valC=0x100 -> bytes 70 00 01 00 00 00 00 00 00 at addresses 10..18; wr_ptr=19.
- icode=0xC -> err_invalid high exactly one cycle; no wr_en; wr_ptr unchanged; in_ready back high next cycle.
- base_load 1020, then rmmovq -> err_overflow=1, no writes, in_ready=0; clear_err -> IDLE with err_overflow=0.
- rst_n low after 3 bytes of an irmovq -> wr_en=0 immediately; wr_ptr=0; state IDLE; no further bytes written.
- pushq with rA=4, rB=5 -> byte1=0x4F with Y86_ENC_FIELD_FORCE_EN defined, 0x45 without.
